// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core pipeline registers.
//   CTRLW / CTRL_*   : width and bit positions of the packed control word
//                      {RegWrite,MemRead,MemWrite,MemtoReg,RegDst,Branch,Jump,
//                       ALUSrc,ShamtSelector}, RegWrite in the MSB.
//   REG_ZERO         : architectural $zero register number.
//   ALUOPW / ALUOP_* : ALU operation classes, shared with the ALU control.
//   ST_RUN/ST_BUBBLE : ID/EX bubble FSM encodings.
//   action_e         : what the ID/EX register does on the coming edge.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int CTRLW = 9;

    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_SHAMTSEL = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int ALUOPW = 3;
    localparam logic [ALUOPW-1:0] ALUOP_ADD   = 3'd0;
    localparam logic [ALUOPW-1:0] ALUOP_SUB   = 3'd1;
    localparam logic [ALUOPW-1:0] ALUOP_RTYPE = 3'd2;
    localparam logic [ALUOPW-1:0] ALUOP_AND   = 3'd3;
    localparam logic [ALUOPW-1:0] ALUOP_OR    = 3'd4;
    localparam logic [ALUOPW-1:0] ALUOP_SLT   = 3'd5;
    localparam logic [ALUOPW-1:0] ALUOP_LUI   = 3'd6;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    // Resolved per-edge action, highest priority first.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_FLUSH  = 2'd1,
        ACT_HAZARD = 2'd2,
        ACT_LOAD   = 2'd3
    } action_e;

    // True when the control word describes a load (the only producer whose
    // result is not yet available to a dependent instruction in EX).
    function automatic logic is_load(input logic [CTRLW-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/load_use_hazard_detector.sv
// -----------------------------------------------------------------------------
// load_use_hazard_detector
// Pure combinational load-use compare between the instruction in EX and the
// instruction sitting in ID.
//   ex_valid_i    : EX holds a real instruction
//   ex_mem_read_i : EX instruction is a load
//   ex_rt_i       : load destination (Rt)
//   id_valid_i    : ID holds a real instruction
//   id_rs_i       : ID source Rs (always read)
//   id_rt_i       : ID source Rt (read only when id_uses_rt_i)
//   id_uses_rt_i  : ID instruction reads Rt as a source
//   hazard_o      : ID must wait one cycle behind the load
// -----------------------------------------------------------------------------
module load_use_hazard_detector
    import mips_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);

    // Loads into $zero write nothing, so they can never feed a dependent.
    assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                      (rs_match || rt_match) && id_valid_i;

endmodule

// File: rtl/id_ex_hazard_register.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_register
// ID/EX pipeline register with load-use bubble insertion, branch/jump flush,
// global hold and a pending-flush memory for flushes that arrive during hold.
//   clk, reset          : pipeline clock, asynchronous active-low reset
//   Hold                : freeze all state (memory wait); Stall forced high
//   Flush               : squash the instruction entering EX
//   ID_*                : decoded instruction from ID (Valid, Rs, Rt, Rd,
//                         UsesRt, Ctrl, ALUOp and the datapath operands)
//   EX_*                : registered copies of every ID_* field, one cycle later
//   Stall               : combinational; freezes PC and IF/ID
//   BubbleCount         : saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_hazard_register
    import mips_pkg::*;
#(
    parameter int NBits = 32,
    parameter int CNTW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Hold,
    input  logic              Flush,

    input  logic              ID_Valid,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic              ID_UsesRt,
    input  logic [CTRLW-1:0]  ID_Ctrl,
    input  logic [ALUOPW-1:0] ID_ALUOp,
    input  logic [NBits-1:0]  ID_ReadData1,
    input  logic [NBits-1:0]  ID_ReadData2,
    input  logic [NBits-1:0]  ID_ShamtExtend,
    input  logic [NBits-1:0]  ID_ImmediateExtend,
    input  logic [NBits-1:0]  ID_PC_4,
    input  logic [5:0]        ID_ALUFunction,
    input  logic [25:0]       ID_JumpNoShifted,

    output logic              EX_Valid,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic              EX_UsesRt,
    output logic [CTRLW-1:0]  EX_Ctrl,
    output logic [ALUOPW-1:0] EX_ALUOp,
    output logic [NBits-1:0]  EX_ReadData1,
    output logic [NBits-1:0]  EX_ReadData2,
    output logic [NBits-1:0]  EX_ShamtExtend,
    output logic [NBits-1:0]  EX_ImmediateExtend,
    output logic [NBits-1:0]  EX_PC_4,
    output logic [5:0]        EX_ALUFunction,
    output logic [25:0]       EX_JumpNoShifted,

    output logic              Stall,
    output logic [CNTW-1:0]   BubbleCount
);

    // ---------------------------------------------------------------- state
    logic              valid_q,   valid_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        rd_q,      rd_d;
    logic              uses_rt_q, uses_rt_d;
    logic [CTRLW-1:0]  ctrl_q,    ctrl_d;
    logic [ALUOPW-1:0] aluop_q,   aluop_d;
    logic [NBits-1:0]  rd1_q,     rd1_d;
    logic [NBits-1:0]  rd2_q,     rd2_d;
    logic [NBits-1:0]  shamt_q,   shamt_d;
    logic [NBits-1:0]  imm_q,     imm_d;
    logic [NBits-1:0]  pc4_q,     pc4_d;
    logic [5:0]        func_q,    func_d;
    logic [25:0]       jump_q,    jump_d;

    logic [0:0]        state_q,         state_d;
    logic              flush_pending_q, flush_pending_d;
    logic [CNTW-1:0]   count_q,         count_d;

    logic              hazard_raw;
    logic              hazard;
    action_e           action;

    // ------------------------------------------------------ hazard compare
    load_use_hazard_detector u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (is_load(ctrl_q)),
        .ex_rt_i       (rt_q),
        .id_valid_i    (ID_Valid),
        .id_rs_i       (ID_Rs),
        .id_rt_i       (ID_Rt),
        .id_uses_rt_i  (ID_UsesRt),
        .hazard_o      (hazard_raw)
    );

    // In BUBBLE the EX slot is already empty, so the compare cannot fire;
    // gating on RUN keeps that guarantee explicit rather than incidental.
    assign hazard = hazard_raw && (state_q == ST_RUN);

    // ---------------------------------------------------- action priority
    always_comb begin
        if (Hold) begin
            action = ACT_HOLD;
        end else if (Flush || flush_pending_q) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_HAZARD;
        end else begin
            action = ACT_LOAD;
        end
    end

    // Flush overrides a hazard: the dependent instruction is being squashed
    // anyway, so the front end must keep moving to fetch the branch target.
    // Held low in reset so the front end sees a clean, unstalled pipe.
    assign Stall = reset && ((action == ACT_HOLD) || (action == ACT_HAZARD));

    // --------------------------------------------------------- next state
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case below can leave one unassigned and infer a latch.
        valid_d         = valid_q;
        rs_d            = rs_q;
        rt_d            = rt_q;
        rd_d            = rd_q;
        uses_rt_d       = uses_rt_q;
        ctrl_d          = ctrl_q;
        aluop_d         = aluop_q;
        rd1_d           = rd1_q;
        rd2_d           = rd2_q;
        shamt_d         = shamt_q;
        imm_d           = imm_q;
        pc4_d           = pc4_q;
        func_d          = func_q;
        jump_d          = jump_q;
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        count_d         = count_q;

        if (action != ACT_HOLD) begin
            // Data fields follow ID even for a bubble: don't-care in EX, but
            // deterministic instead of stale.
            valid_d   = ID_Valid;
            rs_d      = ID_Rs;
            rt_d      = ID_Rt;
            rd_d      = ID_Rd;
            uses_rt_d = ID_UsesRt;
            ctrl_d    = ID_Ctrl;
            aluop_d   = ID_ALUOp;
            rd1_d     = ID_ReadData1;
            rd2_d     = ID_ReadData2;
            shamt_d   = ID_ShamtExtend;
            imm_d     = ID_ImmediateExtend;
            pc4_d     = ID_PC_4;
            func_d    = ID_ALUFunction;
            jump_d    = ID_JumpNoShifted;
            state_d   = ST_RUN;
        end

        case (action)
            ACT_HOLD: begin
                // A flush during hold would otherwise be lost; replay it on
                // the first edge after release.
                flush_pending_d = flush_pending_q || Flush;
            end
            ACT_FLUSH, ACT_HAZARD: begin
                valid_d         = 1'b0;
                ctrl_d          = '0;
                aluop_d         = '0;
                flush_pending_d = 1'b0;
                count_d         = (&count_q) ? count_q : count_q + CNTW'(1);
                if (action == ACT_HAZARD) begin
                    state_d = ST_BUBBLE;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------- flops
    // Every flop is reset, so EX sees a clean, invalid slot out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q         <= 1'b0;
            rs_q            <= '0;
            rt_q            <= '0;
            rd_q            <= '0;
            uses_rt_q       <= 1'b0;
            ctrl_q          <= '0;
            aluop_q         <= '0;
            rd1_q           <= '0;
            rd2_q           <= '0;
            shamt_q         <= '0;
            imm_q           <= '0;
            pc4_q           <= '0;
            func_q          <= '0;
            jump_q          <= '0;
            state_q         <= ST_RUN;
            flush_pending_q <= 1'b0;
            count_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of order.
            valid_q         <= valid_d;
            rs_q            <= rs_d;
            rt_q            <= rt_d;
            rd_q            <= rd_d;
            uses_rt_q       <= uses_rt_d;
            ctrl_q          <= ctrl_d;
            aluop_q         <= aluop_d;
            rd1_q           <= rd1_d;
            rd2_q           <= rd2_d;
            shamt_q         <= shamt_d;
            imm_q           <= imm_d;
            pc4_q           <= pc4_d;
            func_q          <= func_d;
            jump_q          <= jump_d;
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            count_q         <= count_d;
        end
    end

    // ----------------------------------------------------------- outputs
    assign EX_Valid           = valid_q;
    assign EX_Rs              = rs_q;
    assign EX_Rt              = rt_q;
    assign EX_Rd              = rd_q;
    assign EX_UsesRt          = uses_rt_q;
    assign EX_Ctrl            = ctrl_q;
    assign EX_ALUOp           = aluop_q;
    assign EX_ReadData1       = rd1_q;
    assign EX_ReadData2       = rd2_q;
    assign EX_ShamtExtend     = shamt_q;
    assign EX_ImmediateExtend = imm_q;
    assign EX_PC_4            = pc4_q;
    assign EX_ALUFunction     = func_q;
    assign EX_JumpNoShifted   = jump_q;
    assign BubbleCount        = count_q;

endmodule

// File: tb/tb_id_ex_hazard_register.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_register
// Drives two copies of id_ex_hazard_register from the same stimulus: one with
// the default 16-bit counter and one with a 2-bit counter so saturation is
// reachable in a few bubbles. A reference model of the EX register predicts
// the next EX contents; predictions are queued at drive time and compared
// after the edge. Table rows carry the hand-derived Stall, EX_Valid and
// BubbleCount for each edge.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_register;

    localparam int NB = 32;
    localparam int CW = 16;
    localparam int CWS = 2;

    localparam logic [8:0] C_LW   = 9'b110100010;
    localparam logic [8:0] C_ADD  = 9'b100010000;
    localparam logic [8:0] C_SW   = 9'b001000010;
    localparam logic [8:0] C_ADDI = 9'b100000010;

    typedef struct packed {
        logic       hold;
        logic       flush;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       uses_rt;
        logic [8:0] ctrl;
        logic [2:0] aluop;
    } in_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] shamt;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [5:0]  func;
        logic [25:0] jmp;
    } dat_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rt;
        logic [8:0]  ctrl;
        logic [2:0]  aluop;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] shamt;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [5:0]  func;
        logic [25:0] jmp;
    } ex_t;

    typedef struct {
        in_t in;
        bit  stall;
        bit  valid;
        int  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic Hold, Flush, ID_Valid, ID_UsesRt;
    logic [4:0] ID_Rs, ID_Rt, ID_Rd;
    logic [8:0] ID_Ctrl;
    logic [2:0] ID_ALUOp;
    logic [NB-1:0] ID_ReadData1, ID_ReadData2, ID_ShamtExtend, ID_ImmediateExtend, ID_PC_4;
    logic [5:0]  ID_ALUFunction;
    logic [25:0] ID_JumpNoShifted;

    logic EX_Valid, EX_UsesRt, Stall;
    logic [4:0] EX_Rs, EX_Rt, EX_Rd;
    logic [8:0] EX_Ctrl;
    logic [2:0] EX_ALUOp;
    logic [NB-1:0] EX_ReadData1, EX_ReadData2, EX_ShamtExtend, EX_ImmediateExtend, EX_PC_4;
    logic [5:0]  EX_ALUFunction;
    logic [25:0] EX_JumpNoShifted;
    logic [CW-1:0] BubbleCount;

    logic s_Valid, s_UsesRt, s_Stall;
    logic [4:0] s_Rs, s_Rt, s_Rd;
    logic [8:0] s_Ctrl;
    logic [2:0] s_ALUOp;
    logic [NB-1:0] s_ReadData1, s_ReadData2, s_ShamtExtend, s_ImmediateExtend, s_PC_4;
    logic [5:0]  s_ALUFunction;
    logic [25:0] s_JumpNoShifted;
    logic [CWS-1:0] s_BubbleCount;

    ex_t act, act_s;
    assign act = {EX_Valid, EX_Rs, EX_Rt, EX_Rd, EX_UsesRt, EX_Ctrl, EX_ALUOp,
                  EX_ReadData1, EX_ReadData2, EX_ShamtExtend, EX_ImmediateExtend,
                  EX_PC_4, EX_ALUFunction, EX_JumpNoShifted};
    assign act_s = {s_Valid, s_Rs, s_Rt, s_Rd, s_UsesRt, s_Ctrl, s_ALUOp,
                    s_ReadData1, s_ReadData2, s_ShamtExtend, s_ImmediateExtend,
                    s_PC_4, s_ALUFunction, s_JumpNoShifted};

    always #5 clk = ~clk;

    id_ex_hazard_register #(.NBits(NB), .CNTW(CW)) dut (
        .clk(clk), .reset(reset), .Hold(Hold), .Flush(Flush),
        .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_UsesRt(ID_UsesRt), .ID_Ctrl(ID_Ctrl), .ID_ALUOp(ID_ALUOp),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_ShamtExtend(ID_ShamtExtend), .ID_ImmediateExtend(ID_ImmediateExtend),
        .ID_PC_4(ID_PC_4), .ID_ALUFunction(ID_ALUFunction), .ID_JumpNoShifted(ID_JumpNoShifted),
        .EX_Valid(EX_Valid), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_UsesRt(EX_UsesRt), .EX_Ctrl(EX_Ctrl), .EX_ALUOp(EX_ALUOp),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
        .EX_ShamtExtend(EX_ShamtExtend), .EX_ImmediateExtend(EX_ImmediateExtend),
        .EX_PC_4(EX_PC_4), .EX_ALUFunction(EX_ALUFunction), .EX_JumpNoShifted(EX_JumpNoShifted),
        .Stall(Stall), .BubbleCount(BubbleCount)
    );

    id_ex_hazard_register #(.NBits(NB), .CNTW(CWS)) dut_s (
        .clk(clk), .reset(reset), .Hold(Hold), .Flush(Flush),
        .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_UsesRt(ID_UsesRt), .ID_Ctrl(ID_Ctrl), .ID_ALUOp(ID_ALUOp),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_ShamtExtend(ID_ShamtExtend), .ID_ImmediateExtend(ID_ImmediateExtend),
        .ID_PC_4(ID_PC_4), .ID_ALUFunction(ID_ALUFunction), .ID_JumpNoShifted(ID_JumpNoShifted),
        .EX_Valid(s_Valid), .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_Rd(s_Rd),
        .EX_UsesRt(s_UsesRt), .EX_Ctrl(s_Ctrl), .EX_ALUOp(s_ALUOp),
        .EX_ReadData1(s_ReadData1), .EX_ReadData2(s_ReadData2),
        .EX_ShamtExtend(s_ShamtExtend), .EX_ImmediateExtend(s_ImmediateExtend),
        .EX_PC_4(s_PC_4), .EX_ALUFunction(s_ALUFunction), .EX_JumpNoShifted(s_JumpNoShifted),
        .Stall(s_Stall), .BubbleCount(s_BubbleCount)
    );

    int   errors = 0;
    int   checks = 0;
    ex_t  m_ex;
    bit   m_fp;
    ex_t  sb_q[$];
    vec_t tbl[15];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic in_t ins(input bit hold, input bit flush, input bit valid,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input bit uses, input logic [8:0] ctrl, input logic [2:0] aluop);
        in_t v;
        v.hold = hold; v.flush = flush; v.valid = valid;
        v.rs = rs; v.rt = rt; v.rd = rd; v.uses_rt = uses;
        v.ctrl = ctrl; v.aluop = aluop;
        return v;
    endfunction

    // Reference model of one edge, written from the priority rules.
    task automatic model_step(input in_t v, input dat_t d);
        bit haz;
        bit bub;
        haz = m_ex.valid && m_ex.ctrl[7] && (m_ex.rt != 5'd0) &&
              ((m_ex.rt == v.rs) || (v.uses_rt && (m_ex.rt == v.rt))) && v.valid;
        if (v.hold) begin
            if (v.flush) m_fp = 1'b1;
        end else begin
            bub = v.flush || m_fp || haz;
            m_fp = 1'b0;
            m_ex.valid   = bub ? 1'b0 : v.valid;
            m_ex.ctrl    = bub ? 9'd0 : v.ctrl;
            m_ex.aluop   = bub ? 3'd0 : v.aluop;
            m_ex.rs      = v.rs;
            m_ex.rt      = v.rt;
            m_ex.rd      = v.rd;
            m_ex.uses_rt = v.uses_rt;
            m_ex.rd1     = d.rd1;
            m_ex.rd2     = d.rd2;
            m_ex.shamt   = d.shamt;
            m_ex.imm     = d.imm;
            m_ex.pc4     = d.pc4;
            m_ex.func    = d.func;
            m_ex.jmp     = d.jmp;
        end
    endtask

    task automatic step(input in_t v, input bit exp_stall, input bit exp_valid, input int exp_cnt);
        dat_t d;
        ex_t  e;
        int   exp_s;
        d.rd1 = $urandom; d.rd2 = $urandom; d.shamt = $urandom;
        d.imm = $urandom; d.pc4 = $urandom;
        d.func = 6'($urandom); d.jmp = 26'($urandom);
        @(negedge clk);
        Hold = v.hold; Flush = v.flush; ID_Valid = v.valid;
        ID_Rs = v.rs; ID_Rt = v.rt; ID_Rd = v.rd; ID_UsesRt = v.uses_rt;
        ID_Ctrl = v.ctrl; ID_ALUOp = v.aluop;
        ID_ReadData1 = d.rd1; ID_ReadData2 = d.rd2; ID_ShamtExtend = d.shamt;
        ID_ImmediateExtend = d.imm; ID_PC_4 = d.pc4;
        ID_ALUFunction = d.func; ID_JumpNoShifted = d.jmp;
        #1;
        check("stall", 256'(Stall), 256'(exp_stall));
        check("stall_s", 256'(s_Stall), 256'(exp_stall));
        model_step(v, d);
        sb_q.push_back(m_ex);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        exp_s = (exp_cnt > 3) ? 3 : exp_cnt;
        check("ex_fields", 256'(act), 256'(e));
        check("ex_fields_s", 256'(act_s), 256'(e));
        check("ex_valid", 256'(EX_Valid), 256'(exp_valid));
        check("bubble_count", 256'(BubbleCount), 256'(exp_cnt));
        check("bubble_count_sat", 256'(s_BubbleCount), 256'(exp_s));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ex"}, 256'(act), 256'(0));
        check({tag, "_ex_s"}, 256'(act_s), 256'(0));
        check({tag, "_stall"}, 256'(Stall), 256'(0));
        check({tag, "_count"}, 256'(BubbleCount), 256'(0));
        check({tag, "_count_s"}, 256'(s_BubbleCount), 256'(0));
    endtask

    initial begin
        reset = 1'b0;
        Hold = 0; Flush = 0; ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_Rd = 0;
        ID_UsesRt = 0; ID_Ctrl = 0; ID_ALUOp = 0;
        ID_ReadData1 = 0; ID_ReadData2 = 0; ID_ShamtExtend = 0;
        ID_ImmediateExtend = 0; ID_PC_4 = 0; ID_ALUFunction = 0; ID_JumpNoShifted = 0;
        m_ex = '0;
        m_fp = 1'b0;

        // {hold, flush, valid, rs, rt, rd, uses_rt, ctrl, aluop}, stall, EX_Valid, count
        // lw $8 then dependent add: one bubble, then the add issues
        tbl[0]  = '{ins(0,0,1, 29, 8, 0, 0, C_LW,   3'd0), 0, 1, 0};
        tbl[1]  = '{ins(0,0,1,  8,10, 9, 1, C_ADD,  3'd2), 1, 0, 1};
        tbl[2]  = '{ins(0,0,1,  8,10, 9, 1, C_ADD,  3'd2), 0, 1, 1};
        // lw $0 then reader of $0: no stall
        tbl[3]  = '{ins(0,0,1, 29, 0, 0, 0, C_LW,   3'd0), 0, 1, 1};
        tbl[4]  = '{ins(0,0,1,  0, 1, 9, 1, C_ADD,  3'd2), 0, 1, 1};
        // lw $8 then sw reading Rt=$8: stall
        tbl[5]  = '{ins(0,0,1, 29, 8, 0, 0, C_LW,   3'd0), 0, 1, 1};
        tbl[6]  = '{ins(0,0,1, 29, 8, 0, 1, C_SW,   3'd0), 1, 0, 2};
        tbl[7]  = '{ins(0,0,1, 29, 8, 0, 1, C_SW,   3'd0), 0, 1, 2};
        // lw $8 then addi with rt=$8 as destination only: no stall
        tbl[8]  = '{ins(0,0,1, 29, 8, 0, 0, C_LW,   3'd0), 0, 1, 2};
        tbl[9]  = '{ins(0,0,1, 29, 8, 0, 0, C_ADDI, 3'd3), 0, 1, 2};
        // dependent but ID slot not valid: no stall, passes as invalid
        tbl[10] = '{ins(0,0,1, 29, 8, 0, 0, C_LW,   3'd0), 0, 1, 2};
        tbl[11] = '{ins(0,0,0,  8,10, 9, 1, C_ADD,  3'd2), 0, 0, 2};
        // flush and hazard together: bubble without stall
        tbl[12] = '{ins(0,0,1, 29, 8, 0, 0, C_LW,   3'd0), 0, 1, 2};
        tbl[13] = '{ins(0,1,1,  8,10, 9, 1, C_ADD,  3'd2), 0, 0, 3};
        tbl[14] = '{ins(0,0,1,  8,10, 9, 1, C_ADD,  3'd2), 0, 1, 3};

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        #3;
        reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].stall, tbl[i].valid, tbl[i].cnt);
        end

        // Flush during a 3-cycle hold: EX frozen, flush replayed on release
        for (int i = 0; i < 3; i++) begin
            step(ins(1,1,1, 8, 8, 0, 0, C_LW, 3'd0), 1, 1, 3);
        end
        step(ins(0,0,1, 5, 6, 7, 1, C_ADD, 3'd2), 0, 0, 4);
        step(ins(0,0,1, 5, 6, 7, 1, C_ADD, 3'd2), 0, 1, 4);

        // Hazard pending under hold: stall held, EX frozen, then bubble
        step(ins(0,0,1, 29, 8, 0, 0, C_LW,  3'd0), 0, 1, 4);
        step(ins(1,0,1,  8, 3, 9, 1, C_ADD, 3'd2), 1, 1, 4);
        step(ins(0,0,1,  8, 3, 9, 1, C_ADD, 3'd2), 1, 0, 5);

        // Now in BUBBLE with the 2-bit counter saturated at 3: async reset
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("midreset");
        m_ex = '0;
        m_fp = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        check_reset_state("midreset_held");
        #3;
        reset = 1'b1;

        // First post-reset instruction passes; counter restarts from 0
        step(ins(0,0,1,  8, 3, 9, 1, C_ADD, 3'd2), 0, 1, 0);
        step(ins(0,0,1, 29, 8, 0, 0, C_LW,  3'd0), 0, 1, 0);
        step(ins(0,0,1,  8, 3, 9, 1, C_ADD, 3'd2), 1, 0, 1);
        step(ins(0,0,1,  8, 3, 9, 1, C_ADD, 3'd2), 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
